// File: rtl/pwm_btn_ctrl_if.sv
// Button/pulse bundle between the push-button front end and its neighbours.
//   inc_btn, dec_btn : raw push-button levels (asynchronous, may bounce)
//   inc, dec         : one-cycle adjust pulses toward the PWM duty generator
//   lock             : high while both buttons are held (conflict)
// master drives the buttons and observes the pulses; slave is the controller.
interface pwm_btn_ctrl_if;
    logic inc_btn;
    logic dec_btn;
    logic inc;
    logic dec;
    logic lock;

    modport master (output inc_btn, output dec_btn, input inc, input dec, input lock);
    modport slave  (input inc_btn, input dec_btn, output inc, output dec, output lock);
endinterface

// File: rtl/pwm_btn_ctrl.sv
// pwm_btn_ctrl: push-button front end for the PWM duty-cycle generator.
// Each raw button is 2-FF synchronised, debounced and edge-detected. A clean
// press gives a single-cycle inc/dec pulse. Pressing both buttons locks out
// all pulses until both are released.
//   clk_in : system clock, rising edge
//   rst    : asynchronous active-low reset
//   bus    : pwm_btn_ctrl_if.slave (inc_btn/dec_btn in; inc/dec/lock out, all registered)
// Build option: define AUTO_REPEAT_EN to add the hold-to-repeat behaviour
// (REPEAT state and repeat counter). Without it each debounced press gives
// exactly one pulse and REPEAT_DELAY/REPEAT_RATE have no effect.
//
// state  | meaning
// IDLE   | no button accepted; waiting for a debounced rising level
// HOLD   | one button held after its first pulse (dir says which)
// REPEAT | button still held, pulsing every REPEAT_RATE cycles (AUTO_REPEAT_EN only)
// LOCK   | both buttons held; no pulses until both are released
module pwm_btn_ctrl #(
    parameter int DB_CYCLES    = 16,
    parameter int REPEAT_DELAY = 200,
    parameter int REPEAT_RATE  = 50,
    parameter int CNT_W        = 16
) (
    input logic           clk_in,
    input logic           rst,
    pwm_btn_ctrl_if.slave bus
);

    if (DB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
        DB_CYCLES > (1 << CNT_W) || REPEAT_DELAY > (1 << CNT_W) ||
        REPEAT_RATE > (1 << CNT_W)) begin : g_param_check
        $error("pwm_btn_ctrl: parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_t;
`endif

    // Bit 0 is the increment button, bit 1 the decrement button.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       stable;
    logic [1:0]       stable_d;
    logic [1:0]       rise;
    logic [CNT_W-1:0] db_cnt [2];

    state_t state, state_nx;
    logic   dir, dir_nx;          // 0 = inc held, 1 = dec held
    logic   inc_nx, dec_nx;
    logic   inc_q, dec_q, lock_q;
    logic   own_lvl, other_lvl;
`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] rcnt, rcnt_nx;
`endif

    assign raw = {bus.dec_btn, bus.inc_btn};

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            stable    <= '0;
            stable_d  <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                // Any cycle that agrees with the accepted level restarts the count,
                // so a bounce anywhere inside the window rejects the change.
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != '1) begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise      = stable & ~stable_d;
    assign own_lvl   = dir ? stable[1] : stable[0];
    assign other_lvl = dir ? stable[0] : stable[1];

    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        inc_nx   = 1'b0;
        dec_nx   = 1'b0;
`ifdef AUTO_REPEAT_EN
        rcnt_nx  = '0;
`endif
        case (state)
            IDLE: begin
                if (stable[0] && stable[1]) begin
                    state_nx = LOCK;
                end else if (rise[0]) begin
                    inc_nx   = 1'b1;
                    dir_nx   = 1'b0;
                    state_nx = HOLD;
                end else if (rise[1]) begin
                    dec_nx   = 1'b1;
                    dir_nx   = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (!own_lvl) begin
                    state_nx = IDLE;
                end else if (other_lvl) begin
                    state_nx = LOCK;
                end
`ifdef AUTO_REPEAT_EN
                else if (rcnt == DELAY_LAST) begin
                    inc_nx   = ~dir;
                    dec_nx   = dir;
                    state_nx = REPEAT;
                end else begin
                    rcnt_nx = (rcnt == '1) ? rcnt : rcnt + 1'b1;
                end
`endif
            end
`ifdef AUTO_REPEAT_EN
            REPEAT: begin
                if (!own_lvl) begin
                    state_nx = IDLE;
                end else if (other_lvl) begin
                    state_nx = LOCK;
                end else if (rcnt == RATE_LAST) begin
                    inc_nx = ~dir;
                    dec_nx = dir;
                end else begin
                    rcnt_nx = (rcnt == '1) ? rcnt : rcnt + 1'b1;
                end
            end
`endif
            LOCK: begin
                if (!stable[0] && !stable[1]) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            dir    <= 1'b0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            lock_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rcnt   <= '0;
`endif
        end else begin
            state  <= state_nx;
            dir    <= dir_nx;
            inc_q  <= inc_nx;
            dec_q  <= dec_nx;
            lock_q <= (state_nx == LOCK);
`ifdef AUTO_REPEAT_EN
            rcnt   <= rcnt_nx;
`endif
        end
    end

    assign bus.inc  = inc_q;
    assign bus.dec  = dec_q;
    assign bus.lock = lock_q;

endmodule
